// File: rtl/gemm_vec_sequencer.sv
// Input/output vector buffer and launch sequencer for one vwb_gemm layer engine.
// Loads an input vector, serves weight-aligned chunks while the engine runs, then holds the result row vector.
module gemm_vec_sequencer #(
    parameter int InVecLength  = 16,
    parameter int OutVecLength = 8,
    parameter int WorkingRegs  = 4,
    parameter int NBits        = 12
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          vec_in_valid,
    input  logic [NBits-1:0]              vec_in_data,
    output logic                          vec_in_ready,
    output logic                          gemm_in_data_ready,
    output logic [WorkingRegs*NBits-1:0]  gemm_in_data,
    input  logic                          req_chunk_in,
    input  logic                          req_chunk_ptr_rst,
    input  logic                          req_chunk_out,
    input  logic [NBits-1:0]              gemm_write_out_data,
    output logic                          out_valid,
    output logic [OutVecLength*NBits-1:0] out_data,
    input  logic                          out_ack,
    output logic                          busy,
    output logic                          seq_err
);

    localparam int Chunks = InVecLength / WorkingRegs;
    localparam int LoadW  = (InVecLength > 1) ? $clog2(InVecLength) : 1;
    localparam int ChunkW = (Chunks > 1) ? $clog2(Chunks) : 1;
    localparam int OutW   = (OutVecLength > 1) ? $clog2(OutVecLength) : 1;

    localparam logic [LoadW-1:0]  LastLoad  = LoadW'(InVecLength - 1);
    localparam logic [ChunkW-1:0] LastChunk = ChunkW'(Chunks - 1);
    localparam logic [OutW-1:0]   LastOut   = OutW'(OutVecLength - 1);

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_e;

    state_e              state_q;
    logic [LoadW-1:0]    load_idx_q;
    logic [ChunkW-1:0]   chunk_ptr_q;
    logic [OutW-1:0]     out_idx_q;
    logic                launch_q;
    logic                out_valid_q;
    logic                seq_err_q;

    logic [NBits-1:0]    in_buf_q  [InVecLength];
    logic [NBits-1:0]    out_buf_q [OutVecLength];

    logic                in_we;
    logic                out_we;
    logic                engine_req;
    logic [LoadW-1:0]    chunk_base;

    assign in_we      = (state_q == LOAD) && vec_in_valid;
    assign out_we     = (state_q == RUN) && req_chunk_out;
    assign engine_req = req_chunk_out || req_chunk_in || req_chunk_ptr_rst;
    assign chunk_base = LoadW'(int'(chunk_ptr_q) * WorkingRegs);

    // NOTE: the vector buffers carry no reset; their contents are meaningless until loaded,
    // and leaving them out of the reset net lets them map onto plain storage.
    always_ff @(posedge clk_in) begin
        if (in_we) begin
            in_buf_q[load_idx_q] <= vec_in_data;
        end
        if (out_we) begin
            out_buf_q[out_idx_q] <= gemm_write_out_data;
        end
    end

    // NOTE: all state below is updated with non-blocking assignments so every branch
    // sees the pre-edge values of the other registers.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q     <= LOAD;
            load_idx_q  <= '0;
            chunk_ptr_q <= '0;
            out_idx_q   <= '0;
            launch_q    <= 1'b0;
            out_valid_q <= 1'b0;
            seq_err_q   <= 1'b0;
        end else begin
            launch_q <= 1'b0;
            if (state_q != RUN && engine_req) begin
                seq_err_q <= 1'b1;
            end
            case (state_q)
                LOAD: begin
                    if (vec_in_valid) begin
                        if (load_idx_q == LastLoad) begin
                            load_idx_q  <= '0;
                            chunk_ptr_q <= '0;
                            out_idx_q   <= '0;
                            launch_q    <= 1'b1;
                            state_q     <= RUN;
                        end else begin
                            load_idx_q <= load_idx_q + 1'b1;
                        end
                    end
                end
                RUN: begin
                    // Rewind wins over advance when the engine asserts both.
                    if (req_chunk_ptr_rst) begin
                        chunk_ptr_q <= '0;
                    end else if (req_chunk_in) begin
                        chunk_ptr_q <= (chunk_ptr_q == LastChunk) ? '0 : chunk_ptr_q + 1'b1;
                    end
                    if (req_chunk_out) begin
                        if (out_idx_q == LastOut) begin
                            out_valid_q <= 1'b1;
                            state_q     <= HOLD;
                        end else begin
                            out_idx_q <= out_idx_q + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (out_ack) begin
                        out_valid_q <= 1'b0;
                        out_idx_q   <= '0;
                        state_q     <= LOAD;
                    end
                end
                default: begin
                    state_q <= LOAD;
                end
            endcase
        end
    end

    // NOTE: every combinational output gets a default before the loop so no latch is inferred.
    always_comb begin
        gemm_in_data = '0;
        for (int i = 0; i < WorkingRegs; i++) begin
            gemm_in_data[i*NBits +: NBits] = in_buf_q[chunk_base + LoadW'(i)];
        end
    end

    always_comb begin
        out_data = '0;
        for (int r = 0; r < OutVecLength; r++) begin
            out_data[r*NBits +: NBits] = out_buf_q[r];
        end
    end

    assign vec_in_ready       = (state_q == LOAD);
    assign busy               = (state_q != LOAD);
    assign gemm_in_data_ready = launch_q;
    assign out_valid          = out_valid_q;
    assign seq_err            = seq_err_q;

endmodule

// File: tb/tb_gemm_vec_sequencer.sv
// Directed bench for gemm_vec_sequencer: load, launch, chunk walk, collect, hold, error and reset abort.
module tb_gemm_vec_sequencer;

    logic        clk_in;
    logic        rst_in;
    logic        vec_in_valid;
    logic [11:0] vec_in_data;
    logic        vec_in_ready;
    logic        gemm_in_data_ready;
    logic [47:0] gemm_in_data;
    logic        req_chunk_in;
    logic        req_chunk_ptr_rst;
    logic        req_chunk_out;
    logic [11:0] gemm_write_out_data;
    logic        out_valid;
    logic [95:0] out_data;
    logic        out_ack;
    logic        busy;
    logic        seq_err;

    int vectors;
    int miscompares;

    localparam logic [47:0] Chunk0    = {12'd4, 12'd3, 12'd2, 12'd1};
    localparam logic [47:0] Chunk1    = {12'd8, 12'd7, 12'd6, 12'd5};
    localparam logic [47:0] Chunk3    = {12'd16, 12'd15, 12'd14, 12'd13};
    localparam logic [47:0] ChunkNeg  = {12'hFFC, 12'hFFD, 12'hFFE, 12'hFFF};
    localparam logic [47:0] ChunkNew  = {12'd20, 12'd19, 12'd18, 12'd17};
    localparam logic [95:0] OutVec    = {12'h017, 12'h016, 12'h015, 12'h014,
                                         12'h013, 12'h012, 12'h011, 12'h010};

    gemm_vec_sequencer dut (
        .clk_in              (clk_in),
        .rst_in              (rst_in),
        .vec_in_valid        (vec_in_valid),
        .vec_in_data         (vec_in_data),
        .vec_in_ready        (vec_in_ready),
        .gemm_in_data_ready  (gemm_in_data_ready),
        .gemm_in_data        (gemm_in_data),
        .req_chunk_in        (req_chunk_in),
        .req_chunk_ptr_rst   (req_chunk_ptr_rst),
        .req_chunk_out       (req_chunk_out),
        .gemm_write_out_data (gemm_write_out_data),
        .out_valid           (out_valid),
        .out_data            (out_data),
        .out_ack             (out_ack),
        .busy                (busy),
        .seq_err             (seq_err)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic load_vector(input int first, input int step);
        for (int k = 0; k < 16; k++) begin
            vec_in_valid = 1'b1;
            vec_in_data  = 12'(first + step * k);
            tick();
            if (k == 14) check("no_early_launch", 128'(gemm_in_data_ready), 128'(1'b0));
        end
        vec_in_valid = 1'b0;
    endtask

    initial begin
        vectors             = 0;
        miscompares         = 0;
        rst_in              = 1'b0;
        vec_in_valid        = 1'b0;
        vec_in_data         = '0;
        req_chunk_in        = 1'b0;
        req_chunk_ptr_rst   = 1'b0;
        req_chunk_out       = 1'b0;
        gemm_write_out_data = '0;
        out_ack             = 1'b0;

        #12;
        check("rst_busy",      128'(busy),               128'(1'b0));
        check("rst_out_valid", 128'(out_valid),          128'(1'b0));
        check("rst_launch",    128'(gemm_in_data_ready), 128'(1'b0));
        check("rst_seq_err",   128'(seq_err),            128'(1'b0));
        rst_in = 1'b1;
        tick();
        check("post_rst_ready", 128'(vec_in_ready), 128'(1'b1));

        // Load 1..16 and launch.
        load_vector(1, 1);
        check("launch_pulse",    128'(gemm_in_data_ready), 128'(1'b1));
        check("run_busy",        128'(busy),               128'(1'b1));
        check("run_not_ready",   128'(vec_in_ready),       128'(1'b0));
        check("chunk0",          128'(gemm_in_data),       128'(Chunk0));
        tick();
        check("launch_one_cycle", 128'(gemm_in_data_ready), 128'(1'b0));

        // Chunk walk with wrap and rewind priority.
        req_chunk_in = 1'b1;
        tick();
        check("chunk1", 128'(gemm_in_data), 128'(Chunk1));
        tick();
        tick();
        req_chunk_in = 1'b0;
        check("chunk3", 128'(gemm_in_data), 128'(Chunk3));
        req_chunk_in = 1'b1;
        tick();
        check("chunk_wrap", 128'(gemm_in_data), 128'(Chunk0));
        tick();
        check("chunk1_again", 128'(gemm_in_data), 128'(Chunk1));
        req_chunk_ptr_rst = 1'b1;
        tick();
        req_chunk_in      = 1'b0;
        req_chunk_ptr_rst = 1'b0;
        check("rewind_priority", 128'(gemm_in_data), 128'(Chunk0));
        check("no_err_in_run",   128'(seq_err),      128'(1'b0));

        // Collect eight results.
        for (int r = 0; r < 8; r++) begin
            req_chunk_out       = 1'b1;
            gemm_write_out_data = 12'(12'h010 + r);
            tick();
            if (r == 6) check("no_early_valid", 128'(out_valid), 128'(1'b0));
        end
        req_chunk_out = 1'b0;
        check("out_valid_rise", 128'(out_valid), 128'(1'b1));
        check("out_data",       128'(out_data),  128'(OutVec));

        // Hold without ack while upstream pushes an element.
        vec_in_valid = 1'b1;
        vec_in_data  = 12'hABC;
        for (int c = 0; c < 5; c++) begin
            check("hold_valid",     128'(out_valid),    128'(1'b1));
            check("hold_data",      128'(out_data),     128'(OutVec));
            check("hold_not_ready", 128'(vec_in_ready), 128'(1'b0));
            tick();
        end
        check("hold_inbuf_kept", 128'(gemm_in_data), 128'(Chunk0));
        vec_in_valid = 1'b0;

        // Result overflow while holding.
        req_chunk_out       = 1'b1;
        gemm_write_out_data = 12'hFFF;
        tick();
        req_chunk_out = 1'b0;
        check("err_set",        128'(seq_err),  128'(1'b1));
        check("err_data_kept",  128'(out_data), 128'(OutVec));
        tick();
        check("err_sticky",     128'(seq_err),   128'(1'b1));
        check("err_still_hold", 128'(out_valid), 128'(1'b1));

        // Acknowledge and return to LOAD.
        out_ack = 1'b1;
        tick();
        out_ack = 1'b0;
        check("ack_valid_low", 128'(out_valid),    128'(1'b0));
        check("ack_ready",     128'(vec_in_ready), 128'(1'b1));
        check("ack_idle",      128'(busy),         128'(1'b0));

        // Negative values stream through bit-exact, then reset aborts mid-RUN.
        load_vector(-1, -1);
        check("neg_launch", 128'(gemm_in_data_ready), 128'(1'b1));
        check("neg_chunk0", 128'(gemm_in_data),       128'(ChunkNeg));
        tick();
        #2;
        rst_in = 1'b0;
        #1;
        check("abort_busy",      128'(busy),               128'(1'b0));
        check("abort_out_valid", 128'(out_valid),          128'(1'b0));
        check("abort_launch",    128'(gemm_in_data_ready), 128'(1'b0));
        check("abort_seq_err",   128'(seq_err),            128'(1'b0));
        rst_in = 1'b1;
        tick();
        check("rerun_ready", 128'(vec_in_ready), 128'(1'b1));

        load_vector(17, 1);
        check("rerun_launch", 128'(gemm_in_data_ready), 128'(1'b1));
        check("rerun_chunk0", 128'(gemm_in_data),       128'(ChunkNew));
        check("rerun_no_err", 128'(seq_err),            128'(1'b0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
